// File: rtl/glb_pkg.sv
// Shared types and width helpers for the global-buffer writer.
package glb_pkg;

    localparam int GLB_STATE_W = 2;

    typedef enum logic [GLB_STATE_W-1:0] {
        IDLE,
        WRITE,
        FLUSH,
        DONE
    } glb_wr_state_e;

    function automatic int glb_addr_w(input int size);
        return $clog2(size);
    endfunction

    function automatic int glb_cnt_w(input int size);
        return $clog2(size) + 1;
    endfunction

    function automatic int glb_idx_w(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

endpackage

// File: rtl/glb_row_packer.sv
// Collects accepted words into lane registers and presents the packed row,
// zero-padding every lane at or above the current fill index.
module glb_row_packer
    import glb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          accept,
    input  logic [DATA_WIDTH-1:0]         data,
    input  logic                          clear,
    output logic                          row_full,
    output logic [DATA_WIDTH*NUM_COL-1:0] row_data
);

    localparam int IW = glb_idx_w(NUM_COL);
    localparam logic [IW-1:0] LAST = IW'(NUM_COL - 1);

    logic [DATA_WIDTH-1:0] lanes [NUM_COL];
    logic [IW-1:0]         idx;

    assign row_full = accept && (idx == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx <= '0;
            for (int i = 0; i < NUM_COL; i++) begin
                lanes[i] <= '0;
            end
        end else if (clear) begin
            idx <= '0;
        end else if (accept) begin
            lanes[idx] <= data;
            idx        <= (idx == LAST) ? '0 : idx + IW'(1);
        end
    end

    // The beat being accepted is merged in so a full row can be written
    // on the same edge that takes its last word.
    always_comb begin
        row_data = '0;
        for (int i = 0; i < NUM_COL; i++) begin
            if (IW'(i) < idx) begin
                row_data[i*DATA_WIDTH +: DATA_WIDTH] = lanes[i];
            end else if ((IW'(i) == idx) && accept) begin
                row_data[i*DATA_WIDTH +: DATA_WIDTH] = data;
            end
        end
    end

endmodule

// File: rtl/glb_buf_writer.sv
// Packs a stream of words into rows of a circular global buffer and tracks
// occupancy against reader pops. Define GLB_WR_ERR_EN for the sticky err flag.
module glb_buf_writer
    import glb_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_COL     = 8,
    parameter int BUFFER_SIZE = 512,
    parameter int LEN_W       = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           cfg_start,
    input  logic [LEN_W-1:0]               cfg_len,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic                           rd_pop,
    output logic                           wr_en,
    output logic [$clog2(BUFFER_SIZE)-1:0] wr_addr,
    output logic [DATA_WIDTH*NUM_COL-1:0]  wr_data,
    output logic                           rd_avail,
    output logic [$clog2(BUFFER_SIZE):0]   count,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int AW = glb_addr_w(BUFFER_SIZE);
    localparam int CW = glb_cnt_w(BUFFER_SIZE);
    localparam int RW = DATA_WIDTH * NUM_COL;
    localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

    glb_wr_state_e    state;
    glb_wr_state_e    state_n;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] remaining_n;
    logic [AW-1:0]    ptr;
    logic [CW-1:0]    count_n;
    logic [RW-1:0]    row_data;
    logic             not_full;
    logic             accept;
    logic             row_full;
    logic             row_wr;
    logic             flush_wr;
    logic             pop_ok;
    logic             done_n;

    assign not_full = (count != FULL);
    assign s_ready  = (state == WRITE) && not_full;
    assign accept   = s_valid && s_ready;
    assign busy     = (state != IDLE);
    assign pop_ok   = rd_pop && (count != '0);

    glb_row_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_COL    (NUM_COL)
    ) u_packer (
        .clk      (clk),
        .rstn     (rstn),
        .accept   (accept),
        .data     (s_data),
        .clear    (flush_wr),
        .row_full (row_full),
        .row_data (row_data)
    );

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        row_wr      = 1'b0;
        flush_wr    = 1'b0;
        done_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_start) begin
                    remaining_n = cfg_len;
                    state_n     = (cfg_len == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (accept) begin
                    remaining_n = remaining - LEN_W'(1);
                    row_wr      = row_full;
                    if (remaining == LEN_W'(1)) begin
                        state_n = row_full ? DONE : FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (not_full) begin
                    row_wr   = 1'b1;
                    flush_wr = 1'b1;
                    state_n  = DONE;
                end
            end
            DONE: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A row write and a pop in the same cycle cancel out.
    always_comb begin
        count_n = count;
        if (row_wr && !pop_ok) begin
            count_n = count + CW'(1);
        end else if (!row_wr && pop_ok) begin
            count_n = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            ptr      <= '0;
            count    <= '0;
            rd_avail <= 1'b0;
            done     <= 1'b0;
        end else begin
            wr_en    <= row_wr;
            count    <= count_n;
            rd_avail <= (count_n != '0);
            done     <= done_n;
            if (row_wr) begin
                wr_addr <= ptr;
                wr_data <= row_data;
                ptr     <= ptr + AW'(1);
            end
        end
    end

`ifdef GLB_WR_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if ((rd_pop && (count == '0)) || (cfg_start && busy)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
